hostctrl_loader: RTL

- Target end of the host-control boot path. The host streams a program image one byte at a time over a valid/ack handshake and signals end of stream with a done line.
- The block packs the bytes big-endian into 32-bit words. It writes each word to main memory as a single-beat Wishbone master.
- The CPU is held in reset until the image is fully committed.
- Sits in orpsoc_top between the hostctrl pins and a master port of the memory interconnect.

---
 rtl/hostctrl_loader.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/hostctrl_loader.sv
// hostctrl_loader: boot-image loader at the target end of the host-control path.
// Bytes arrive one at a time over a valid/ack handshake. They are packed
// big-endian into 32-bit words, and each word is written to memory as one
// classic single-beat Wishbone write. The CPU is held in reset until the
// whole image has been committed.
//
// Build option: define HOSTCTRL_LOADER_TIMEOUT_EN to abort a bus cycle that
// sees neither ack nor err within WB_TIMEOUT cycles. Such a cycle is handled
// like an err response. When the macro is undefined there is no counter, and
// a bus cycle waits for the slave indefinitely.
module hostctrl_loader #(
  parameter logic [31:0] BASE_ADR   = 32'h0000_0000,
  parameter logic [31:0] MEM_SIZE   = 32'h0200_0000,
  parameter int          WB_TIMEOUT = 256
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [7:0]  hostctrl_data,
  input  logic        hostctrl_valid,
  input  logic        hostctrl_done,
  output logic        hostctrl_ack,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_we_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic [2:0]  wbm_cti_o,
  output logic [1:0]  wbm_bte_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  output logic        cpu_rst_o,
  output logic        load_done_o,
  output logic        load_err_o,
  output logic [23:0] word_cnt_o
);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    WRITE   = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [1:0]  idx_reg, idx_next;
  logic [31:0] dat_reg, dat_next;
  logic [31:0] adr_reg, adr_next;
  logic [23:0] cnt_reg, cnt_next;
  logic        ack_reg, ack_next;
  logic        cyc_reg, cyc_next;
  logic        err_reg, err_next;
  logic        full_reg, full_next;
  logic        flush_reg, flush_next;
  logic        cpu_rst_reg, cpu_rst_next;
  logic        done_reg, done_next;

  logic [31:0] packed_word;
  logic        overflow;
  logic        timeout;
  logic        bus_end;
  logic        bus_fail;

  // The read data bus is not needed by a write-only master.
  logic unused_ok;
  assign unused_ok = ^wbm_dat_i;

  // The limit is computed with a carry bit so that a region ending exactly at
  // the top of the 32-bit space does not wrap around to zero.
  assign overflow = ({1'b0, adr_reg} >= ({1'b0, BASE_ADR} + {1'b0, MEM_SIZE}));

  // Byte index i lands in lane 3-i (big-endian). Capturing index 0 starts a
  // new word, so that capture also clears the other lanes. This makes a
  // partial word at end of stream zero-padded without any extra step.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign packed_word[8*gi +: 8] =
      (idx_reg == 2'(3 - gi)) ? hostctrl_data :
      (idx_reg == 2'd0)       ? 8'h00         :
                                dat_reg[8*gi +: 8];
  end

`ifdef HOSTCTRL_LOADER_TIMEOUT_EN
  localparam int TMO_W = $clog2(WB_TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_cnt_reg;

  // Count the cycles spent in WRITE. The count restarts from zero on every
  // entry into WRITE.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || state_reg != WRITE) begin
      tmo_cnt_reg <= '0;
    end else begin
      tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
    end
  end

  // Fires in the last cycle of the WB_TIMEOUT-cycle window.
  assign timeout = (state_reg == WRITE) && (tmo_cnt_reg == TMO_W'(WB_TIMEOUT - 1));
`else
  logic unused_tmo_param;
  assign unused_tmo_param = WB_TIMEOUT[0];
  assign timeout = 1'b0;
`endif

  // An err response wins over a simultaneous ack. A timeout counts as err.
  assign bus_fail = wbm_err_i | timeout;
  assign bus_end  = wbm_ack_i | bus_fail;

  // State register. Reset drops any bus cycle in progress, discards the
  // partial word and restarts loading from BASE_ADR.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_reg   <= COLLECT;
      idx_reg     <= 2'd0;
      dat_reg     <= 32'h0;
      adr_reg     <= BASE_ADR;
      cnt_reg     <= 24'h0;
      ack_reg     <= 1'b0;
      cyc_reg     <= 1'b0;
      err_reg     <= 1'b0;
      full_reg    <= 1'b0;
      flush_reg   <= 1'b0;
      cpu_rst_reg <= 1'b1;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      dat_reg     <= dat_next;
      adr_reg     <= adr_next;
      cnt_reg     <= cnt_next;
      ack_reg     <= ack_next;
      cyc_reg     <= cyc_next;
      err_reg     <= err_next;
      full_reg    <= full_next;
      flush_reg   <= flush_next;
      cpu_rst_reg <= cpu_rst_next;
      done_reg    <= done_next;
    end
  end

  // Next-state logic: byte capture, word packing, bus cycle control.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    dat_next   = dat_reg;
    adr_next   = adr_reg;
    cnt_next   = cnt_reg;
    ack_next   = 1'b0;
    cyc_next   = cyc_reg;
    err_next   = err_reg;
    full_next  = full_reg;
    flush_next = flush_reg;

    case (state_reg)
      COLLECT: begin
        if (full_reg) begin
          // This is the ack cycle of the fourth byte. The bus cycle starts
          // here, so it never overlaps a byte ack. A word past the end of
          // memory is dropped and only the error flag records it.
          full_next = 1'b0;
          if (overflow) begin
            err_next = 1'b1;
          end else begin
            state_next = WRITE;
            cyc_next   = 1'b1;
            flush_next = 1'b0;
          end
        end else if (hostctrl_valid && !ack_reg) begin
          dat_next = packed_word;
          ack_next = 1'b1;
          idx_next = idx_reg + 2'd1;
          if (idx_reg == 2'd3) begin
            full_next = 1'b1;
          end
        end else if (hostctrl_done && !hostctrl_valid && !ack_reg) begin
          if (idx_reg != 2'd0) begin
            idx_next = 2'd0;
            if (overflow) begin
              err_next   = 1'b1;
              state_next = DONE;
            end else begin
              state_next = WRITE;
              cyc_next   = 1'b1;
              flush_next = 1'b1;
            end
          end else begin
            state_next = DONE;
          end
        end
      end

      WRITE: begin
        if (bus_end) begin
          cyc_next   = 1'b0;
          adr_next   = adr_reg + 32'd4;
          cnt_next   = cnt_reg + 24'd1;
          state_next = flush_reg ? DONE : COLLECT;
          if (bus_fail) begin
            err_next = 1'b1;
          end
        end
      end

      DONE: begin
        state_next = DONE;
      end

      default: begin
        state_next = COLLECT;
        cyc_next   = 1'b0;
      end
    endcase

    // CPU release and the done flag are both registered on the edge that
    // enters DONE.
    cpu_rst_next = (state_next != DONE);
    done_next    = (state_next == DONE);
  end

  assign hostctrl_ack = ack_reg;
  assign wbm_adr_o    = adr_reg;
  assign wbm_dat_o    = dat_reg;
  assign wbm_sel_o    = 4'hF;
  assign wbm_we_o     = cyc_reg;
  assign wbm_cyc_o    = cyc_reg;
  assign wbm_stb_o    = cyc_reg;
  assign wbm_cti_o    = 3'b000;
  assign wbm_bte_o    = 2'b00;
  assign cpu_rst_o    = cpu_rst_reg;
  assign load_done_o  = done_reg;
  assign load_err_o   = err_reg;
  assign word_cnt_o   = cnt_reg;

endmodule
